// File: rtl/trng_pkg.sv
// Shared types and helpers for the multi-lane ring-oscillator TRNG.
package trng_pkg;

  typedef enum logic {VN_EMPTY, VN_HAVE_ONE} vn_state_t;

  // Lane i gets two more inverters than lane i-1 so the lanes stay odd-length and mutually detuned
  function automatic int ro_len(input int stages, input int i);
    return stages + 2 * i;
  endfunction

endpackage

// File: rtl/trng_ro_lane.sv
// One free-running ring oscillator; a clocked twisted-ring stand-in is used outside synthesis.
module trng_ro_lane #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic n_reset,
  output logic ro_out
);

`ifdef SYNTHESIS
  (* keep *) logic [STAGES-1:0] ring;

  assign ring[0] = ~ring[STAGES-1];
  for (genvar k = 1; k < STAGES; k++) begin : g_inv
    assign ring[k] = ~ring[k-1];
  end
  assign ro_out = ring[STAGES-1];
`else
  logic [STAGES-1:0] q;

  always_ff @(posedge clk) begin
    if (!n_reset) q <= '0;
    else          q <= {q[STAGES-2:0], ~q[STAGES-1]};
  end
  assign ro_out = q[STAGES-1];
`endif

endmodule

// File: rtl/trng_multi_ro.sv
// Multi-lane TRNG: lane XOR, sync, divided sampling, repetition health test,
// optional von Neumann debias and a word assembler on a valid/ready stream.
module trng_multi_ro
  import trng_pkg::*;
#(
  parameter int NUM_RO     = 4,
  parameter int RO_STAGES  = 3,
  parameter int OUT_W      = 8,
  parameter int SAMPLE_DIV = 4,
  parameter int VN_EN      = 1,
  parameter int REP_LIMIT  = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             enable,
  input  logic             test_en,
  input  logic             test_bit,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             health_fail
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = $clog2(OUT_W + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [NUM_RO-1:0] ro;

  for (genvar g = 0; g < NUM_RO; g++) begin : g_lane
    trng_ro_lane #(.STAGES(ro_len(RO_STAGES, g))) u_lane (
      .clk    (clk),
      .n_reset(n_reset),
      .ro_out (ro[g])
    );
  end

  logic [1:0] xsync;
  logic       raw;

  always_ff @(posedge clk) begin
    if (!n_reset) xsync <= '0;
    else          xsync <= {xsync[0], ^ro};
  end

  assign raw = test_en ? test_bit : xsync[1];

  logic [DW-1:0] div_cnt;
  logic          strobe;

  assign strobe = enable && (div_cnt == DW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (!n_reset)    div_cnt <= '0;
    else if (strobe) div_cnt <= '0;
    else if (enable) div_cnt <= div_cnt + 1'b1;
  end

  // rep_cnt==0 marks "no previous sample" so the first sample after reset starts a fresh run
  logic          prev_raw;
  logic [RW-1:0] rep_cnt, rep_nxt;
  logic          trip, sample;

  always_comb begin
    rep_nxt = rep_cnt;
    if (rep_cnt == '0 || raw != prev_raw) rep_nxt = RW'(1);
    else if (rep_cnt != RW'(REP_LIMIT))   rep_nxt = rep_cnt + 1'b1;
  end

  assign trip   = strobe && (rep_nxt == RW'(REP_LIMIT));
  assign sample = strobe && !health_fail;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      prev_raw    <= 1'b0;
      rep_cnt     <= '0;
      health_fail <= 1'b0;
    end else if (strobe) begin
      prev_raw <= raw;
      rep_cnt  <= rep_nxt;
      if (trip) health_fail <= 1'b1;
    end
  end

  vn_state_t vn_st, vn_nxt;
  logic      vn_first, bit_ok, bit_val;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      vn_st    <= VN_EMPTY;
      vn_first <= 1'b0;
    end else begin
      vn_st <= vn_nxt;
      if (sample && vn_st == VN_EMPTY) vn_first <= raw;
    end
  end

  always_comb begin
    vn_nxt = vn_st;
    if (trip)                      vn_nxt = VN_EMPTY;
    else if (sample && VN_EN != 0) vn_nxt = (vn_st == VN_EMPTY) ? VN_HAVE_ONE : VN_EMPTY;
  end

  always_comb begin
    bit_ok  = 1'b0;
    bit_val = raw;
    if (VN_EN == 0) bit_ok = sample;
    else if (sample && vn_st == VN_HAVE_ONE && vn_first != raw) begin
      bit_ok  = 1'b1;
      bit_val = vn_first;
    end
  end

  logic [OUT_W-1:0] shift_reg, next_word;
  logic [CW-1:0]    bit_cnt;
  logic             xfer, slot_free, held, last;

  assign xfer      = out_valid && out_ready;
  assign slot_free = !out_valid || out_ready;
  assign held      = (bit_cnt == CW'(OUT_W));
  assign last      = bit_ok && (bit_cnt == CW'(OUT_W - 1));
  assign next_word = {shift_reg[OUT_W-2:0], bit_val};

  // A held word moves out on the freeing edge; a bit accepted on that edge starts the next word
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (trip) begin
      out_valid <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (held && slot_free) begin
      out_data  <= shift_reg;
      out_valid <= 1'b1;
      if (bit_ok) begin
        shift_reg <= next_word;
        bit_cnt   <= CW'(1);
      end else begin
        bit_cnt   <= '0;
      end
    end else if (last && slot_free) begin
      out_data  <= next_word;
      out_valid <= 1'b1;
      shift_reg <= next_word;
      bit_cnt   <= '0;
    end else begin
      if (bit_ok && !held) begin
        shift_reg <= next_word;
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (xfer) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trng_multi_ro.sv
// Directed bench: four DUT configurations sharing clock, reset and test stimulus.
module tb_trng_multi_ro;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       test_en = 1'b1;
  logic       test_bit = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] en = '0;

  logic [7:0] d_raw, d_vn, d_hl, d_div;
  logic       v_raw, v_vn, v_hl, v_div;
  logic       hf_raw, hf_vn, hf_hl, hf_div;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trng_multi_ro #(.NUM_RO(4), .RO_STAGES(3), .OUT_W(8), .SAMPLE_DIV(1), .VN_EN(0), .REP_LIMIT(16)) u_raw (
    .clk(clk), .n_reset(n_reset), .enable(en[0]), .test_en(test_en), .test_bit(test_bit),
    .out_data(d_raw), .out_valid(v_raw), .out_ready(out_ready), .health_fail(hf_raw));

  trng_multi_ro #(.NUM_RO(4), .RO_STAGES(3), .OUT_W(8), .SAMPLE_DIV(1), .VN_EN(1), .REP_LIMIT(16)) u_vn (
    .clk(clk), .n_reset(n_reset), .enable(en[1]), .test_en(test_en), .test_bit(test_bit),
    .out_data(d_vn), .out_valid(v_vn), .out_ready(out_ready), .health_fail(hf_vn));

  trng_multi_ro #(.NUM_RO(4), .RO_STAGES(3), .OUT_W(8), .SAMPLE_DIV(1), .VN_EN(0), .REP_LIMIT(8)) u_hl (
    .clk(clk), .n_reset(n_reset), .enable(en[2]), .test_en(test_en), .test_bit(test_bit),
    .out_data(d_hl), .out_valid(v_hl), .out_ready(out_ready), .health_fail(hf_hl));

  trng_multi_ro #(.NUM_RO(4), .RO_STAGES(3), .OUT_W(8), .SAMPLE_DIV(4), .VN_EN(0), .REP_LIMIT(16)) u_div (
    .clk(clk), .n_reset(n_reset), .enable(en[3]), .test_en(test_en), .test_bit(test_bit),
    .out_data(d_div), .out_valid(v_div), .out_ready(out_ready), .health_fail(hf_div));

  // Inputs change and outputs are observed on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    en      = '0;
    step();
    step();
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    logic any_v;
    test_en = 1'b0;
    do_reset();
    n_reset = 1'b0;
    total++;
    if ({v_raw, v_vn, v_hl, v_div} !== 4'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0000", {v_raw, v_vn, v_hl, v_div});
    end
    total++;
    if ({d_raw, d_vn, d_hl, d_div} !== 32'h0) begin
      bad++; $display("FAIL reset_data got=%h want=00000000", {d_raw, d_vn, d_hl, d_div});
    end
    total++;
    if ({hf_raw, hf_vn, hf_hl, hf_div} !== 4'b0) begin
      bad++; $display("FAIL reset_health got=%b want=0000", {hf_raw, hf_vn, hf_hl, hf_div});
    end
    n_reset = 1'b1;
    any_v   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      any_v |= v_raw | v_vn | v_hl | v_div;
    end
    total++;
    if (any_v !== 1'b0) begin
      bad++; $display("FAIL disabled_no_valid got=%b want=0", any_v);
    end
    test_en = 1'b1;
  endtask

  task automatic test_raw_word();
    logic [7:0] w = 8'hB2;
    int vcnt = 0;
    do_reset();
    out_ready = 1'b1;
    en[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      test_bit = w[7-i];
      step();
      if (v_raw) vcnt++;
    end
    total++;
    if (v_raw !== 1'b1 || d_raw !== 8'hB2) begin
      bad++; $display("FAIL raw_word got=%b/%h want=1/b2", v_raw, d_raw);
    end
    en[0] = 1'b0;
    step();
    if (v_raw) vcnt++;
    step();
    if (v_raw) vcnt++;
    total++;
    if (vcnt != 1) begin
      bad++; $display("FAIL raw_valid_cycles got=%0d want=1", vcnt);
    end
  endtask

  task automatic test_vn();
    logic [19:0] s = 20'b10_11_01_00_10_10_01_10_01_01;
    logic early = 1'b0;
    do_reset();
    out_ready = 1'b1;
    en[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      test_bit = s[19-i];
      step();
      if (i < 19) early |= v_vn;
    end
    total++;
    if (early !== 1'b0) begin
      bad++; $display("FAIL vn_early_valid got=%b want=0", early);
    end
    total++;
    if (v_vn !== 1'b1 || d_vn !== 8'hB4) begin
      bad++; $display("FAIL vn_word got=%b/%h want=1/b4", v_vn, d_vn);
    end
    en[1] = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [26:0] s = {8'hB2, 8'h5A, 3'b111, 8'h3C};
    do_reset();
    out_ready = 1'b0;
    en[0] = 1'b1;
    for (int i = 0; i < 19; i++) begin
      test_bit = s[26-i];
      step();
      if (i == 7) begin
        total++;
        if (v_raw !== 1'b1 || d_raw !== 8'hB2) begin
          bad++; $display("FAIL bp_first got=%b/%h want=1/b2", v_raw, d_raw);
        end
      end
    end
    total++;
    if (v_raw !== 1'b1 || d_raw !== 8'hB2) begin
      bad++; $display("FAIL bp_hold got=%b/%h want=1/b2", v_raw, d_raw);
    end
    en[0] = 1'b0;
    out_ready = 1'b1;
    step();
    total++;
    if (v_raw !== 1'b1 || d_raw !== 8'h5A) begin
      bad++; $display("FAIL bp_release got=%b/%h want=1/5a", v_raw, d_raw);
    end
    step();
    total++;
    if (v_raw !== 1'b0) begin
      bad++; $display("FAIL bp_drain got=%b want=0", v_raw);
    end
    en[0] = 1'b1;
    for (int i = 19; i < 27; i++) begin
      test_bit = s[26-i];
      step();
    end
    total++;
    if (v_raw !== 1'b1 || d_raw !== 8'h3C) begin
      bad++; $display("FAIL bp_dropped_bits got=%b/%h want=1/3c", v_raw, d_raw);
    end
    en[0] = 1'b0;
  endtask

  task automatic test_health();
    logic any_v = 1'b0;
    do_reset();
    out_ready = 1'b1;
    en[2] = 1'b1;
    test_bit = 1'b1;
    for (int i = 0; i < 7; i++) step();
    total++;
    if (hf_hl !== 1'b0) begin
      bad++; $display("FAIL health_early got=%b want=0", hf_hl);
    end
    step();
    total++;
    if (hf_hl !== 1'b1 || v_hl !== 1'b0 || d_hl !== 8'h00) begin
      bad++; $display("FAIL health_trip got=%b/%b/%h want=1/0/00", hf_hl, v_hl, d_hl);
    end
    for (int i = 0; i < 20; i++) begin
      test_bit = i[0];
      step();
      any_v |= v_hl;
    end
    total++;
    if (any_v !== 1'b0 || hf_hl !== 1'b1) begin
      bad++; $display("FAIL health_sticky got=%b/%b want=0/1", any_v, hf_hl);
    end
    do_reset();
    total++;
    if (hf_hl !== 1'b0) begin
      bad++; $display("FAIL health_reset got=%b want=0", hf_hl);
    end
  endtask

  task automatic test_divider();
    logic [7:0] w = 8'h5A;
    logic early = 1'b0;
    do_reset();
    out_ready = 1'b1;
    en[3] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      test_bit = w[7-i];
      for (int c = 0; c < 4; c++) begin
        if (i == 3 && c == 2) begin
          en[3] = 1'b0;
          test_bit = ~w[7-i];
          step(); step(); step();
          test_bit = w[7-i];
          en[3] = 1'b1;
        end
        step();
        if (!(i == 7 && c == 3)) early |= v_div;
      end
    end
    total++;
    if (early !== 1'b0) begin
      bad++; $display("FAIL div_early_valid got=%b want=0", early);
    end
    total++;
    if (v_div !== 1'b1 || d_div !== 8'h5A) begin
      bad++; $display("FAIL div_word got=%b/%h want=1/5a", v_div, d_div);
    end
    en[3] = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_raw_word();
    test_vn();
    test_backpressure();
    test_health();
    test_divider();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
